// File: rtl/product_accumulator.sv
// Sums a frame of unsigned products into an ACC_W-bit score (wraps, or clamps when ACC_SATURATE_EN is defined).
// Latency: last product accepted in cycle N -> score_valid in cycle N+1.
// Backpressure: prod_ready only in ACCUM; score held with score_valid until score_ack.
module product_accumulator #(
    parameter int PROD_W = 32,
    parameter int ACC_W  = 40,
    parameter int LEN_W  = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [LEN_W-1:0]  frame_len,
    input  logic              prod_valid,
    input  logic [PROD_W-1:0] prod_in,
    output logic              prod_ready,
    output logic [ACC_W-1:0]  score,
    output logic              score_valid,
    input  logic              score_ack,
    output logic              busy,
    output logic              overflow
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

    state_t             state;
    state_t             state_nxt;
    logic [ACC_W-1:0]   acc;
    logic [LEN_W-1:0]   len;
    logic [LEN_W-1:0]   count;
    logic               ovf;
    logic [ACC_W:0]     sum;
    logic               carry;
    logic               start_ok;
    logic               xfer;
    logic               last;

    assign start_ok = (state == IDLE) && start;
    assign xfer     = (state == ACCUM) && prod_valid;
    assign last     = ((count + LEN_ONE) == len);

    // One extra bit captures the carry out of the accumulator.
    assign sum   = {1'b0, acc} + (ACC_W + 1)'(prod_in);
    assign carry = sum[ACC_W];

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (frame_len == '0) ? HOLD : ACCUM;
                end
            end
            ACCUM: begin
                if (prod_valid && last) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (score_ack) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc   <= '0;
            len   <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end else if (start_ok) begin
            acc   <= '0;
            len   <= frame_len;
            count <= '0;
            ovf   <= 1'b0;
        end else if (xfer) begin
`ifdef ACC_SATURATE_EN
            // All-ones plus any non-zero product carries again, so the clamp holds.
            acc <= carry ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
            acc <= sum[ACC_W-1:0];
`endif
            count <= count + LEN_ONE;
            if (carry) begin
                ovf <= 1'b1;
            end
        end
    end

    assign prod_ready  = (state == ACCUM);
    assign score_valid = (state == HOLD);
    assign busy        = (state != IDLE);
    assign score       = acc;
    assign overflow    = ovf;

endmodule
